program_memory: RTL and testbench

PROGRAM_MEMORY -- requirements
Module: program_memory

---
 rtl/program_memory_if.sv | 29 ++
 rtl/program_memory.sv | 100 ++++++++++
 tb/tb_program_memory.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/program_memory_if.sv
// Fetch and program-load signal bundle for program_memory.
// The master side issues fetches and streams load words; the slave side is the memory.
interface program_memory_if #(
    parameter int DATA_WIDTH = 28,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] iAddress;
    logic                  iReadEnable;
    logic [DATA_WIDTH-1:0] oInstruction;
    logic                  oValid;

    logic                  iLoadStart;
    logic [DATA_WIDTH-1:0] iLoadData;
    logic                  iLoadValid;
    logic                  iLoadLast;
    logic                  oLoadReady;
    logic                  oLoadDone;
    logic [ADDR_WIDTH:0]   oLoadCount;

    modport master (
        output iAddress, iReadEnable, iLoadStart, iLoadData, iLoadValid, iLoadLast,
        input  oInstruction, oValid, oLoadReady, oLoadDone, oLoadCount
    );

    modport slave (
        input  iAddress, iReadEnable, iLoadStart, iLoadData, iLoadValid, iLoadLast,
        output oInstruction, oValid, oLoadReady, oLoadDone, oLoadCount
    );
endinterface

// File: rtl/program_memory.sv
// Loadable instruction store: a streamed program load fills the array, then
// single-cycle-latency fetches return stored words or DEFAULT_WORD past the loaded length.
module program_memory #(
    parameter int                    DATA_WIDTH   = 28,
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DEPTH        = 256,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'(28'h00000AA)
) (
    input logic             Clock,
    input logic             Reset,
    program_memory_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t                state_reg;
    logic [CNT_W-1:0]      load_count_reg;
    logic                  load_ready_reg;
    logic                  load_done_reg;
    logic                  valid_reg;
    logic [DATA_WIDTH-1:0] instr_reg;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic             accept;
    logic             wr_en;
    logic             final_word;
    logic             fetch_hit;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // load_ready_reg is high exactly while LOADING, so it doubles as the state qualifier.
    assign accept     = bus.iLoadValid & load_ready_reg;
    assign wr_en      = accept & ~bus.iLoadStart & ~Reset;
    assign final_word = bus.iLoadLast | (load_count_reg == DEPTH_M1);
    // The load count is also the write pointer: word n always lands at index n.
    assign wr_idx     = load_count_reg[IDX_W-1:0];
    assign rd_idx     = bus.iAddress[IDX_W-1:0];
    assign fetch_hit  = {1'b0, bus.iAddress} < load_count_reg;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg      <= IDLE;
            load_count_reg <= '0;
            load_ready_reg <= 1'b0;
            load_done_reg  <= 1'b0;
        end else begin
            load_done_reg <= 1'b0;
            if (bus.iLoadStart) begin
                // Starting again mid-load discards any word offered in this cycle.
                state_reg      <= LOADING;
                load_count_reg <= '0;
                load_ready_reg <= 1'b1;
            end else if (state_reg == LOADING && accept) begin
                load_count_reg <= load_count_reg + CNT_W'(1);
                if (final_word) begin
                    state_reg      <= RUN;
                    load_ready_reg <= 1'b0;
                    load_done_reg  <= 1'b1;
                end
            end
        end
    end

    // Storage is never reset; stale words beyond the load count are masked at fetch.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_idx] <= bus.iLoadData;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            instr_reg <= DEFAULT_WORD;
            valid_reg <= 1'b0;
        end else if (state_reg != RUN || bus.iLoadStart) begin
            instr_reg <= DEFAULT_WORD;
            valid_reg <= 1'b0;
        end else if (bus.iReadEnable) begin
            instr_reg <= fetch_hit ? mem[rd_idx] : DEFAULT_WORD;
            valid_reg <= 1'b1;
        end else begin
            valid_reg <= 1'b0;
        end
    end

    assign bus.oInstruction = instr_reg;
    assign bus.oValid       = valid_reg;
    assign bus.oLoadReady   = load_ready_reg;
    assign bus.oLoadDone    = load_done_reg;
    assign bus.oLoadCount   = load_count_reg;

endmodule

// File: tb/tb_program_memory.sv
// Bench for program_memory: vector table and directed corner cases on two
// instances (DEPTH 256 and DEPTH 4), then random traffic against a program-list model.
module tb_program_memory;
    localparam logic [27:0] DEF = 28'h00000AA;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    program_memory_if #(.DATA_WIDTH(28), .ADDR_WIDTH(16)) if_a ();
    program_memory_if #(.DATA_WIDTH(28), .ADDR_WIDTH(16)) if_b ();

    program_memory #(.DATA_WIDTH(28), .ADDR_WIDTH(16), .DEPTH(256)) u_big (
        .Clock (clk),
        .Reset (rst),
        .bus   (if_a.slave)
    );

    program_memory #(.DATA_WIDTH(28), .ADDR_WIDTH(16), .DEPTH(4)) u_small (
        .Clock (clk),
        .Reset (rst),
        .bus   (if_b.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        start;
        logic        lv;
        logic [27:0] data;
        logic        last;
        logic        re;
        logic [15:0] addr;
        logic        e_valid;
        logic [27:0] e_instr;
        logic        e_ready;
        logic        e_done;
        logic [16:0] e_count;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit s, bit lv, logic [27:0] d, bit l, bit re, logic [15:0] a,
                                bit ev, logic [27:0] ei, bit er, bit ed, int ec);
        vec_t v;
        v.start = s; v.lv = lv; v.data = d; v.last = l; v.re = re; v.addr = a;
        v.e_valid = ev; v.e_instr = ei; v.e_ready = er; v.e_done = ed; v.e_count = 17'(ec);
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int m, bit s, bit lv, logic [27:0] d, bit l, bit re, logic [15:0] a);
        if (m == 0) begin
            if_a.iLoadStart = s; if_a.iLoadValid = lv; if_a.iLoadData = d;
            if_a.iLoadLast = l; if_a.iReadEnable = re; if_a.iAddress = a;
        end else begin
            if_b.iLoadStart = s; if_b.iLoadValid = lv; if_b.iLoadData = d;
            if_b.iLoadLast = l; if_b.iReadEnable = re; if_b.iAddress = a;
        end
    endtask

    task automatic chk_out(int m, string tag, bit ev, logic [27:0] ei, bit er, bit ed, int ec);
        if (m == 0) begin
            chk({tag, ".valid"}, 32'(if_a.oValid), 32'(ev));
            chk({tag, ".instr"}, 32'(if_a.oInstruction), 32'(ei));
            chk({tag, ".ready"}, 32'(if_a.oLoadReady), 32'(er));
            chk({tag, ".done"},  32'(if_a.oLoadDone), 32'(ed));
            chk({tag, ".count"}, 32'(if_a.oLoadCount), 32'(ec));
        end else begin
            chk({tag, ".valid"}, 32'(if_b.oValid), 32'(ev));
            chk({tag, ".instr"}, 32'(if_b.oInstruction), 32'(ei));
            chk({tag, ".ready"}, 32'(if_b.oLoadReady), 32'(er));
            chk({tag, ".done"},  32'(if_b.oLoadDone), 32'(ed));
            chk({tag, ".count"}, 32'(if_b.oLoadCount), 32'(ec));
        end
    endtask

    // Reference model: the current program is simply the list of words accepted
    // since the last load start; anything past its length reads as DEF.
    bit          m_loading [2];
    bit          m_running [2];
    int          m_len     [2];
    logic [27:0] m_words   [2][256];
    bit          e_valid   [2];
    logic [27:0] e_instr   [2];
    bit          e_done    [2];

    task automatic model_step(int m, bit r, bit s, bit lv, logic [27:0] d, bit l, bit re, logic [15:0] a);
        int depth = (m == 0) ? 256 : 4;
        if (r) begin
            m_loading[m] = 0; m_running[m] = 0; m_len[m] = 0;
            e_valid[m] = 0; e_instr[m] = DEF; e_done[m] = 0;
            return;
        end
        e_done[m] = 0;
        if (m_running[m] && !s) begin
            if (re) begin
                e_valid[m] = 1;
                e_instr[m] = (int'(a) < m_len[m]) ? m_words[m][a[7:0]] : DEF;
            end else begin
                e_valid[m] = 0;
            end
        end else begin
            e_valid[m] = 0;
            e_instr[m] = DEF;
        end
        if (s) begin
            m_loading[m] = 1; m_running[m] = 0; m_len[m] = 0;
        end else if (m_loading[m] && lv) begin
            m_words[m][m_len[m]] = d;
            m_len[m]++;
            if (l || m_len[m] == depth) begin
                m_loading[m] = 0; m_running[m] = 1; e_done[m] = 1;
            end
        end
    endtask

    initial begin
        drive(0, 0, 0, '0, 0, 0, '0);
        drive(1, 0, 0, '0, 0, 0, '0);

        // Reset state on both instances
        rst = 1'b1;
        drive(0, 1, 1, 28'h1111111, 0, 1, 16'd0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, '0, 0, 0, '0);
        chk_out(0, "reset_big", 0, DEF, 0, 0, 0);
        chk_out(1, "reset_small", 0, DEF, 0, 0, 0);
        $display("tb: reset values checked");

        // Vector table on the DEPTH=256 instance
        vecs.push_back(mk(0,0,28'h0,0,1,16'd0,        0,DEF,0,0,0));
        vecs.push_back(mk(1,0,28'h0,0,0,16'd0,        0,DEF,1,0,0));
        vecs.push_back(mk(0,1,28'h1000001,0,0,16'd0,  0,DEF,1,0,1));
        vecs.push_back(mk(0,1,28'h2000002,0,0,16'd0,  0,DEF,1,0,2));
        vecs.push_back(mk(0,1,28'h3000003,1,0,16'd0,  0,DEF,0,1,3));
        vecs.push_back(mk(0,0,28'h0,0,1,16'd1,        1,28'h2000002,0,0,3));
        vecs.push_back(mk(0,0,28'h0,0,1,16'd3,        1,DEF,0,0,3));
        vecs.push_back(mk(0,0,28'h0,0,1,16'd300,      1,DEF,0,0,3));
        vecs.push_back(mk(0,0,28'h0,0,1,16'd0,        1,28'h1000001,0,0,3));
        vecs.push_back(mk(0,0,28'h0,0,0,16'd2,        0,28'h1000001,0,0,3));
        vecs.push_back(mk(0,1,28'hFFFFFFF,0,1,16'd2,  1,28'h3000003,0,0,3));
        vecs.push_back(mk(1,0,28'h0,0,0,16'd0,        0,DEF,1,0,0));
        vecs.push_back(mk(0,1,28'hABCDEF1,0,0,16'd0,  0,DEF,1,0,1));
        vecs.push_back(mk(0,1,28'h1234567,0,0,16'd0,  0,DEF,1,0,2));
        vecs.push_back(mk(1,1,28'h7777777,0,0,16'd0,  0,DEF,1,0,0));
        vecs.push_back(mk(0,1,28'h5555555,1,0,16'd0,  0,DEF,0,1,1));
        vecs.push_back(mk(0,0,28'h0,0,1,16'd0,        1,28'h5555555,0,0,1));
        vecs.push_back(mk(0,0,28'h0,0,1,16'd1,        1,DEF,0,0,1));
        vecs.push_back(mk(0,0,28'h0,0,1,16'd2,        1,DEF,0,0,1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(0, vecs[i].start, vecs[i].lv, vecs[i].data, vecs[i].last, vecs[i].re, vecs[i].addr);
            tick();
            chk_out(0, $sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr,
                    vecs[i].e_ready, vecs[i].e_done, int'(vecs[i].e_count));
            $display("tb: vec %0d valid=%0b instr=%07h ready=%0b done=%0b count=%0d", i,
                     if_a.oValid, if_a.oInstruction, if_a.oLoadReady, if_a.oLoadDone, if_a.oLoadCount);
        end
        drive(0, 0, 0, '0, 0, 0, '0);

        // DEPTH=4: six words streamed without last, only four accepted
        drive(1, 1, 0, '0, 0, 0, '0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 1, 28'(28'hA00000 + i), 0, 0, '0);
            tick();
            chk_out(1, $sformatf("sat_word%0d", i), 0, DEF, (i < 3), (i == 3), (i < 4) ? i + 1 : 4);
            $display("tb: sat word %0d ready=%0b done=%0b count=%0d", i,
                     if_b.oLoadReady, if_b.oLoadDone, if_b.oLoadCount);
        end
        drive(1, 0, 0, '0, 0, 1, 16'd3);
        tick();
        chk(   "sat_fetch3.instr", 32'(if_b.oInstruction), 32'(28'hA00003));
        drive(1, 0, 0, '0, 0, 1, 16'd4);
        tick();
        chk(   "sat_fetch4.instr", 32'(if_b.oInstruction), 32'(DEF));
        chk(   "sat_fetch4.valid", 32'(if_b.oValid), 32'd1);
        $display("tb: saturation fetch checks done");
        drive(1, 0, 0, '0, 0, 0, '0);

        // Reset together with a load word mid-load, then fetches are ignored
        drive(0, 1, 0, '0, 0, 0, '0);
        tick();
        drive(0, 0, 1, 28'h0CAFE01, 0, 0, '0);
        tick();
        chk("midload.count", 32'(if_a.oLoadCount), 32'd1);
        rst = 1'b1;
        drive(0, 0, 1, 28'h0CAFE02, 1, 1, 16'd0);
        tick();
        rst = 1'b0;
        chk_out(0, "rst_with_load", 0, DEF, 0, 0, 0);
        drive(0, 0, 1, 28'h0CAFE03, 1, 1, 16'd0);
        tick();
        chk_out(0, "idle_after_rst", 0, DEF, 0, 0, 0);
        $display("tb: reset-during-load checks done");

        // Random traffic on both instances against the model
        rst = 1'b1;
        drive(0, 0, 0, '0, 0, 0, '0);
        drive(1, 0, 0, '0, 0, 0, '0);
        model_step(0, 1, 0, 0, '0, 0, 0, '0);
        model_step(1, 1, 0, 0, '0, 0, 0, '0);
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit          r, s, lv, l, re;
            logic [27:0] d;
            logic [15:0] a;
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 39) == 0);
            lv = 1'($urandom_range(0, 1));
            l  = ($urandom_range(0, 9) == 0);
            re = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
            d  = 28'($urandom);
            rst = r;
            for (int m = 0; m < 2; m++) begin
                drive(m, s, lv, d, l, re, a);
                model_step(m, r, s, lv, d, l, re, a);
            end
            tick();
            for (int m = 0; m < 2; m++) begin
                chk_out(m, $sformatf("rand%0d.dut%0d", cyc, m), e_valid[m], e_instr[m],
                        m_loading[m], e_done[m], m_len[m]);
                if (e_done[m])
                    $display("tb: random load done dut=%0d words=%0d cycle=%0d", m, m_len[m], cyc);
            end
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
